latch_bank_arbiter: RTL and testbench
=====================================

Name: latch_bank_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one small single-port storage bank (2**AW words of DW bits) between NREQ requesters.
- Each requester issues a read or write with a level req / one-cycle ack handshake. The arbiter grants one requester at a time, sequences the access and returns read data.
- Sits between the requester logic and the bank inside the memory subsystem.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 3, address width; bank depth = 2**AW.
- DW, 8, data width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level; bit i belongs to requester i.
- we  input  NREQ  per-requester write enable: 1 = write, 0 = read.
- addr  input  NREQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- wdata  input  NREQ*DW  flattened write data; requester i uses bits [i*DW +: DW].
- grant  output  NREQ  one-hot current owner; all zeros when idle.
- ack  output  NREQ  one-cycle completion pulse to the owner.
- rdata  output  DW  read data; valid only in the ack cycle of a read.
- busy  output  1  high while state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; grant=0, ack=0, rdata=0, busy=0.
  - Round-robin pointer ptr=0; all bank words cleared to 0.
  - Reset asserted mid-transaction aborts it: no write, no ack.
- Requester rule: hold req, we, addr and wdata stable from assertion until ack. A req still high in the cycle after ack is a new request.
- FSM, states IDLE, ACCESS, RESP:
  - IDLE: if req != 0, select the first set bit scanning ptr, ptr+1, … mod NREQ. Register grant one-hot and latch the owner index g, then go to ACCESS. If req == 0, stay in IDLE.
  - ACCESS:
    - If req[g]=0 (abort): no bank access, grant=0, go to IDLE, ptr unchanged.
    - Else if we[g]=1: bank[addr_g] <= wdata_g.
    - Else: rdata <= bank[addr_g].
    - After a write or read, ack[g] <= 1 and go to RESP.
  - RESP: ack[g]=1 for exactly this cycle. At the next edge: ack=0, grant=0, ptr <= (g+1) mod NREQ, go to IDLE.
- Timing:
  - Latency: req seen in IDLE in cycle 0 gives ack high in cycle 2.
  - The next arbitration is possible in cycle 3, so peak throughput is one transaction per 3 cycles.
- Bank reads and writes: a write is visible to any later read. A read in the cycle after a write to the same address returns the new data.
- rdata holds its last read value outside RESP and is not updated by writes.
- Fairness: a continuously requesting set is served in strict rotation. No requester waits more than NREQ-1 transactions.
- Requests outside IDLE are ignored until IDLE is reached. A newly raised req with a higher index than g does not preempt.
- Width rules:
  - ptr and g are clog2(NREQ) bits; wrap is mod NREQ, which also holds for non-power-of-2 NREQ.
  - Addresses always lie within the bank depth, so there is no out-of-range case.
- grant is never multi-hot. ack is always a subset of grant.

Decomposition:
- Shared package (mem_pkg):
  - State enum {IDLE, ACCESS, RESP}.
  - clog2 helper function.
  - Default AW/DW constants.
- Sub-module rr_select: combinational round-robin first-one finder. Inputs req and ptr; outputs one-hot and index. Reused by future arbiters.
- Bank storage: a flop array inferred in the top-level block; no separate module.

Test Plan:
- Single write then read: r0 writes addr 3 = 0xA5, then reads addr 3. Each ack appears 2 cycles after req; the read gives rdata=0xA5 and grant=0001 throughout.
- Contention rotation: all 4 requesters hold req from reset (ptr=0). Grants are 0001, 0010, 0100, 1000, 0001 over consecutive 3-cycle windows, with exactly one ack per window.
- Pointer skip: ptr=2 after serving r1, and only req[0] and req[3] are high. r3 is granted first, then r0.
- Abort: r2 drops req during ACCESS of a write of 0x3C to addr 5. No ack; bank[5] stays 0x00 on a later read; ptr is unchanged.
- Reset mid-operation: assert rst_n=0 in RESP. grant, ack, busy and rdata go to 0 immediately (asynchronous). After release, a read of the previously written address returns 0x00.
- Back-to-back same requester: r1 keeps req high after ack with a new addr. A new grant occurs in cycle 3; r1 is re-granted only if no other req is pending, otherwise the pending requester goes first.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-subsystem arbiters.
//   state_e      : sequencer state encoding (IDLE, ACCESS, RESP)
//   clog2()      : constant-foldable ceiling log2, used to size pointers
//   DEF_AW/DEF_DW: default bank address / data widths
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int DEF_AW = 3;
    localparam int DEF_DW = 8;

    // Ceiling log2; returns 0 for n <= 1. Callers that need a usable
    // vector width clamp the result to at least 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : mem_pkg

// File: rtl/rr_select.sv
// Combinational round-robin first-one finder.
// Scans req starting at bit ptr_i and wrapping modulo NREQ (works for
// non-power-of-2 NREQ) and reports the first set bit.
//   req_i     : request vector
//   ptr_i     : index where the scan starts (must be < NREQ)
//   onehot_o  : one-hot of the selected bit, zero when req_i == 0
//   idx_o     : index of the selected bit, zero when req_i == 0
//   any_o     : at least one request is set
module rr_select
    import mem_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int  cand;
        logic found;
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr_i < NREQ, so one conditional subtraction gives the wrap.
            cand = int'(ptr_i) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = PW'(cand);
            end
        end
        any_o = |req_i;
    end

endmodule : rr_select

// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port storage bank
// (2**AW words of DW bits) between NREQ requesters.
//
// Handshake: a requester raises req[i] with we/addr/wdata and holds them
// stable until it sees ack[i] for one cycle. A req still high in the cycle
// after ack is treated as a new request. Dropping req while owning the bus
// before the access happens aborts the transaction (no access, no ack).
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req, we     : per-requester request level / write enable
//   addr, wdata : flattened per-requester address / write data
//   grant       : one-hot current owner, zero when idle
//   ack         : one-cycle completion pulse to the owner
//   rdata       : read data, valid in the ack cycle of a read, held after
//   busy        : sequencer not in IDLE
//   dbg_state_o : current sequencer state, for observation only
module latch_bank_arbiter
    import mem_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output state_e             dbg_state_o
);

    localparam int PW    = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
    localparam int DEPTH = 1 << AW;

    state_e          state_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] ack_q;
    logic [DW-1:0]   rdata_q;
    logic [PW-1:0]   g_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;
    logic [DW-1:0]   bank_q [DEPTH];

    logic [NREQ-1:0] sel_onehot;
    logic [PW-1:0]   sel_idx;
    logic            sel_any;

    // Owner's request fields, muxed by the latched owner index.
    logic            req_g;
    logic            we_g;
    logic [AW-1:0]   addr_g;
    logic [DW-1:0]   wdata_g;

    rr_select #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_select (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (sel_onehot),
        .idx_o    (sel_idx),
        .any_o    (sel_any)
    );

    always_comb begin
        req_g   = 1'b0;
        we_g    = 1'b0;
        addr_g  = '0;
        wdata_g = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_q == PW'(i)) begin
                req_g   = req[i];
                we_g    = we[i];
                addr_g  = addr[i*AW +: AW];
                wdata_g = wdata[i*DW +: DW];
            end
        end
    end

    // Pointer moves past the owner that just completed; explicit wrap so
    // non-power-of-2 NREQ behaves as mod NREQ.
    always_comb begin
        if (g_q == PW'(NREQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = g_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            g_q     <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= '0;
                    if (sel_any) begin
                        grant_q <= sel_onehot;
                        g_q     <= sel_idx;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!req_g) begin
                        // Owner withdrew before the access: release the bank
                        // without touching it; pointer stays where it was.
                        grant_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        if (we_g) begin
                            bank_q[addr_g] <= wdata_g;
                        end else begin
                            rdata_q <= bank_q[addr_g];
                        end
                        ack_q   <= grant_q;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    ack_q   <= '0;
                    grant_q <= '0;
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= '0;
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule : latch_bank_arbiter

// File: tb/tb_latch_bank_arbiter.sv
module tb_latch_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [1:0]         dbg_state;

  always #5 clk = ~clk;

  latch_bank_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .grant       (grant),
    .ack         (ack),
    .rdata       (rdata),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: who owns the bank (-1 = nobody) and how far along the
  // transaction is (0 = none, 1 = granted, 2 = completed this cycle).
  int              m_owner;
  int              m_phase;
  int              m_ptr;
  logic [DW-1:0]   m_mem [DEPTH];
  logic [DW-1:0]   m_rdata;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_phase <= 0;
      m_ptr   <= 0;
      m_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else if (m_phase == 0) begin
      if (req != '0) begin
        m_owner <= rr_pick(req, m_ptr);
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (!req[m_owner]) begin
        m_owner <= -1;
        m_phase <= 0;
      end else begin
        if (we[m_owner]) m_mem[addr[m_owner*AW +: AW]] <= wdata[m_owner*DW +: DW];
        else             m_rdata <= m_mem[addr[m_owner*AW +: AW]];
        m_phase <= 2;
      end
    end else begin
      m_ptr   <= (m_owner + 1) % NREQ;
      m_owner <= -1;
      m_phase <= 0;
    end
  end

  // ---------------- compare process ----------------
  logic [NREQ-1:0] exp_grant;
  logic [NREQ-1:0] exp_ack;

  always @(negedge clk) begin
    if (cmp_en && rst_n === 1'b1) begin
      exp_grant = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
      exp_ack   = (m_phase == 2) ? exp_grant : '0;
      chk("grant", 32'(grant), 32'(exp_grant));
      chk("ack",   32'(ack),   32'(exp_ack));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      chk("busy",  32'(busy),  32'(m_phase != 0));
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("ack_in_grant",  32'(ack & ~grant), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]             = 1'b1;
    we[i]              = w;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
  endtask

  task automatic drop(input int i);
    req[i] = 1'b0;
  endtask

  task automatic new_op(input int i);
    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
            DW'($urandom_range(0, 255)));
  endtask

  task automatic do_reset();
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    rst_n = 1'b0;
    nclk(2);
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    req = '0; we = '0; addr = '0; wdata = '0; rst_n = 1'b0;
    nclk(3);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_ack",   32'(ack),   32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_busy",  32'(busy),  32'd0);

    // Single write then read by r0.
    set_req(0, 1'b1, 3'd3, 8'hA5);
    nclk(1); chk("wr_grant", 32'(grant), 32'h1); chk("wr_ack_early", 32'(ack), 32'h0);
    nclk(1); chk("wr_ack", 32'(ack), 32'h1); drop(0);
    nclk(1); chk("wr_idle_busy", 32'(busy), 32'd0);
    set_req(0, 1'b0, 3'd3, 8'h00);
    nclk(1); chk("rd_grant", 32'(grant), 32'h1);
    nclk(1); chk("rd_ack", 32'(ack), 32'h1); chk("rd_data", 32'(rdata), 32'hA5);
    chk("rd_grant2", 32'(grant), 32'h1);
    drop(0);
    nclk(1);

    // Contention rotation from ptr=0.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), 8'h00);
    for (int k = 0; k < 5; k++) begin
      nclk(1); chk("rot_grant", 32'(grant), 32'(1 << (k % NREQ)));
      nclk(1); chk("rot_ack",   32'(ack),   32'(1 << (k % NREQ)));
      nclk(1); chk("rot_gap",   32'(busy),  32'd0);
    end
    req = '0;
    nclk(1);

    // Pointer skip: serve r1 (ptr -> 2), then r0 and r3 pending.
    do_reset();
    set_req(1, 1'b0, 3'd0, 8'h00);
    nclk(2); drop(1);
    nclk(1);
    set_req(0, 1'b0, 3'd1, 8'h00);
    set_req(3, 1'b0, 3'd2, 8'h00);
    nclk(1); chk("skip_first", 32'(grant), 32'h8);
    nclk(1); drop(3);
    nclk(1);
    nclk(1); chk("skip_second", 32'(grant), 32'h1);
    nclk(1); drop(0);
    nclk(1);

    // Abort: r2 withdraws during ACCESS of a write.
    do_reset();
    set_req(2, 1'b1, 3'd5, 8'h3C);
    nclk(1); chk("abort_grant", 32'(grant), 32'h4); drop(2);
    nclk(1); chk("abort_no_ack", 32'(ack), 32'h0); chk("abort_grant_clr", 32'(grant), 32'h0);
    set_req(0, 1'b0, 3'd5, 8'h00);
    set_req(3, 1'b0, 3'd5, 8'h00);
    nclk(1); chk("abort_ptr_kept", 32'(grant), 32'h1);
    nclk(1); chk("abort_bank", 32'(rdata), 32'h00);
    req = '0;
    nclk(1);

    // Reset in the middle of a RESP cycle.
    set_req(0, 1'b1, 3'd2, 8'h77);
    nclk(2); drop(0);
    nclk(1);
    set_req(0, 1'b0, 3'd2, 8'h00);
    nclk(2); chk("pre_rst_rdata", 32'(rdata), 32'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_ack",   32'(ack),   32'd0);
    chk("arst_busy",  32'(busy),  32'd0);
    chk("arst_rdata", 32'(rdata), 32'd0);
    req = '0;
    nclk(1);
    #2 rst_n = 1'b1;
    set_req(0, 1'b0, 3'd2, 8'h00);
    nclk(2); chk("post_rst_bank", 32'(rdata), 32'h00); chk("post_rst_ack", 32'(ack), 32'h1);
    drop(0);
    nclk(1);

    // Back-to-back r1 (ptr now 1), then r2 pending takes precedence.
    set_req(1, 1'b0, 3'd1, 8'h00);
    nclk(1); chk("b2b_grant", 32'(grant), 32'h2);
    nclk(1); set_req(1, 1'b0, 3'd4, 8'h00);
    nclk(1); chk("b2b_gap", 32'(grant), 32'h0);
    nclk(1); chk("b2b_regrant", 32'(grant), 32'h2);
    set_req(2, 1'b0, 3'd6, 8'h00);
    nclk(1); set_req(1, 1'b0, 3'd7, 8'h00);
    nclk(1);
    nclk(1); chk("b2b_pending_first", 32'(grant), 32'h4);
    nclk(1); drop(2);
    nclk(1);
    nclk(1); chk("b2b_r1_after", 32'(grant), 32'h2);
    nclk(1); drop(1);
    nclk(1);

    // Randomized traffic; requesters react to ack and occasionally abort.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      nclk(1);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ack[i]) begin
          if ($urandom_range(0, 1) == 1) new_op(i);
          else drop(i);
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) drop(i);
        end else if ($urandom_range(0, 2) == 0) begin
          new_op(i);
        end
      end
    end
    req = '0;
    nclk(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_latch_bank_arbiter
